norm_stage: RTL and testbench
=============================

Name: norm_stage

Overview:
- Normalization stage directly downstream of the matrix-multiply unit.
- Consumes matmul result rows once matmul completes and applies a per-run mean/scale normalization with saturation to every lane.
- Streams results onward and raises done_norm to the top-level controller after the last row leaves.
- Two-stage pipeline with full valid/ready backpressure.

Parameters:
- DWIDTH, 8, signed width of each data lane.
- VEC_LANES, 4, lanes per row.
- SHIFT, 4, fractional bits of inv_var (right-shift applied to the product).
- CWIDTH, 8, width of the row counters and num_rows.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start_norm  input  1  level; high while the stage may run (driven from done_mat_mul); low aborts and returns to idle
- num_rows  input  CWIDTH  rows to process; sampled on IDLE->RUN
- mean  input  DWIDTH  signed value subtracted from every lane; sampled on IDLE->RUN
- inv_var  input  DWIDTH  unsigned scale, Q(DWIDTH-SHIFT).SHIFT; sampled on IDLE->RUN
- in_data  input  VEC_LANES*DWIDTH  packed signed lanes, lane 0 in the LSBs
- in_valid  input  1  upstream row valid
- in_ready  output  1  stage accepts row
- out_data  output  VEC_LANES*DWIDTH  normalized row
- out_valid  output  1  output row valid
- out_ready  input  1  downstream accepts row
- done_norm  output  1  all rows emitted; held until start_norm falls

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=0, out_valid=0, out_data=0, done_norm=0; counters, pipeline valids and sampled config are 0.
- State IDLE: on start_norm=1, sample num_rows/mean/inv_var and clear counters.
  - Go to DONE if num_rows==0, else to RUN.
- State RUN: in_ready = adv, where adv = !out_valid || out_ready.
  - Row accepted when in_valid && in_ready; rows_in increments.
  - When rows_in reaches num_rows on an accept, go to DRAIN.
- State DRAIN: in_ready=0. The pipeline keeps advancing on adv.
- DONE condition (RUN or DRAIN): rows_out (incremented on out_valid && out_ready) reaching num_rows moves to DONE.
- State DONE: done_norm=1 (registered), in_ready=0. Stay until start_norm=0.
- start_norm=0 in any state: next cycle state=IDLE; pipeline valids, out_valid and done_norm clear; in-flight rows are discarded.
- Pipeline: both stages advance only when adv=1.
  - Stage 1 registers diff = in - mean per lane, DWIDTH+1 bits, signed.
  - Stage 2 computes prod = diff * inv_var (2*DWIDTH+1 bits), then res = prod >>> SHIFT (arithmetic shift).
  - res saturates to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1], is registered into out_data, and sets out_valid.
- Latency: a row accepted at cycle N appears valid at N+2 when out_ready stays high. Throughput is one row per cycle.
- Stall: when out_valid=1 && out_ready=0, out_data and stage 1 hold, and in_ready=0.
- Simultaneous accept of the last input and emit of an earlier row are both counted that cycle.
- Counters never wrap, because num_rows bounds them.
- out_data holds its last value when out_valid=0.

Optional Feature:
- Macro NORM_RELU_EN.
- Defined: after saturation, negative lanes are forced to 0 in stage 2. Latency is unchanged.
- Undefined: signed saturated result passes through unmodified. No extra ports either way.

Decomposition:
- Shared package holds the state encodings (NORM_IDLE, NORM_RUN, NORM_DRAIN, NORM_DONE) and the saturation min/max constants derived from DWIDTH.
- One sub-module: norm_lane. It is per-lane stage-2 arithmetic (multiply, shift, saturate, optional ReLU), instantiated VEC_LANES times via generate.
- The FSM, counters and handshake stay in norm_stage.

Test Plan (DWIDTH=8, VEC_LANES=4, SHIFT=4):
- Basic: mean=10, inv_var=32, num_rows=2; rows {20,10,0,-6} then {26,10,10,10}, out_ready=1.
  - Outputs {20,0,-20,-32} at accept+2, then {32,0,0,0}.
  - done_norm rises the cycle after the second output handshake.
- Saturation: mean=-128, inv_var=32, lane 127 -> 127; mean=100, lane -100 -> -128.
  - With NORM_RELU_EN: -128 -> 0 and -20 -> 0.
- Backpressure: num_rows=4, out_ready low for 3 cycles after the first output.
  - out_data stable, in_ready=0 during the stall.
  - All 4 rows emitted in order, none dropped or duplicated.
- num_rows=0: start_norm high -> done_norm=1 two cycles later, with no in_ready pulse.
- Abort: drop start_norm after 1 of 3 rows accepted -> next cycle out_valid=0, done_norm=0, state IDLE.
  - Re-raising start restarts with freshly sampled config.
- Async reset mid-RUN: all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared definitions for the normalization stage: FSM encodings and the
// signed saturation bounds for a given lane width.
package norm_pkg;

    typedef enum logic [1:0] {
        NORM_IDLE  = 2'd0,
        NORM_RUN   = 2'd1,
        NORM_DRAIN = 2'd2,
        NORM_DONE  = 2'd3
    } norm_state_t;

    localparam int NORM_DWIDTH = 8;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int NORM_SAT_MAX = sat_max(NORM_DWIDTH);
    localparam int NORM_SAT_MIN = sat_min(NORM_DWIDTH);

endpackage

// File: rtl/norm_lane.sv
// Stage-2 arithmetic for one lane: scale, arithmetic shift, saturate.
// NORM_RELU_EN additionally clamps negative results to zero.
module norm_lane
    import norm_pkg::*;
#(
    parameter int DWIDTH = NORM_DWIDTH,
    parameter int SHIFT  = 4
) (
    input  logic [DWIDTH:0]   i_diff,
    input  logic [DWIDTH-1:0] i_scale,
    output logic [DWIDTH-1:0] o_res
);
    localparam int PW = 2 * DWIDTH + 1;
    localparam logic signed [PW-1:0] SMAX = PW'(sat_max(DWIDTH));
    localparam logic signed [PW-1:0] SMIN = PW'(sat_min(DWIDTH));

    logic signed [PW-1:0]     w_diff_x;
    logic signed [PW-1:0]     w_scale_x;
    logic signed [PW-1:0]     w_prod;
    logic signed [PW-1:0]     w_shr;
    logic        [DWIDTH-1:0] w_sat;

    // Scale is unsigned, so it is zero-extended before the signed multiply.
    assign w_diff_x  = {{(PW-DWIDTH-1){i_diff[DWIDTH]}}, i_diff};
    assign w_scale_x = {{(PW-DWIDTH){1'b0}}, i_scale};
    assign w_prod    = w_diff_x * w_scale_x;
    assign w_shr     = w_prod >>> SHIFT;

    always_comb begin
        w_sat = w_shr[DWIDTH-1:0];
        if (w_shr > SMAX)
            w_sat = SMAX[DWIDTH-1:0];
        else if (w_shr < SMIN)
            w_sat = SMIN[DWIDTH-1:0];
    end

`ifdef NORM_RELU_EN
    assign o_res = w_sat[DWIDTH-1] ? '0 : w_sat;
`else
    assign o_res = w_sat;
`endif

endmodule

// File: rtl/norm_stage.sv
// Mean/scale normalization of matmul rows: two-stage pipeline with
// valid/ready backpressure and a run FSM. Optional ReLU via NORM_RELU_EN.
module norm_stage
    import norm_pkg::*;
#(
    parameter int DWIDTH    = NORM_DWIDTH,
    parameter int VEC_LANES = 4,
    parameter int SHIFT     = 4,
    parameter int CWIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_norm,
    input  logic [CWIDTH-1:0]             num_rows,
    input  logic [DWIDTH-1:0]             mean,
    input  logic [DWIDTH-1:0]             inv_var,
    input  logic [VEC_LANES*DWIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [VEC_LANES*DWIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done_norm
);
    norm_state_t                         r_state;
    logic [CWIDTH-1:0]                   r_num_rows, r_rows_in, r_rows_out;
    logic [DWIDTH-1:0]                   r_mean, r_inv_var;
    logic                                r_s1_vld, r_out_vld, r_done;
    logic [VEC_LANES-1:0][DWIDTH:0]      r_s1_diff;
    logic [VEC_LANES-1:0][DWIDTH-1:0]    r_out;
    logic [VEC_LANES-1:0][DWIDTH:0]      w_diff;
    logic [VEC_LANES-1:0][DWIDTH-1:0]    w_in_lane, w_res;
    logic                                w_adv, w_accept, w_emit, w_in_last, w_out_last;

    assign w_adv      = !r_out_vld || out_ready;
    assign in_ready   = (r_state == NORM_RUN) && w_adv;
    assign w_accept   = in_valid && in_ready;
    assign w_emit     = r_out_vld && out_ready;
    assign w_in_last  = (r_rows_in  + CWIDTH'(1)) == r_num_rows;
    assign w_out_last = (r_rows_out + CWIDTH'(1)) == r_num_rows;

    assign w_in_lane  = in_data;
    assign out_data   = r_out;
    assign out_valid  = r_out_vld;
    assign done_norm  = r_done;

    genvar g;
    generate
        for (g = 0; g < VEC_LANES; g++) begin : g_lane
            assign w_diff[g] = {w_in_lane[g][DWIDTH-1], w_in_lane[g]}
                             - {r_mean[DWIDTH-1], r_mean};
            norm_lane #(.DWIDTH(DWIDTH), .SHIFT(SHIFT)) u_lane (
                .i_diff  (r_s1_diff[g]),
                .i_scale (r_inv_var),
                .o_res   (w_res[g])
            );
        end
    endgenerate

    // Both stages move together; out_data only loads when a real row arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_diff <= '0;
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else if (!start_norm) begin
            r_s1_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= w_accept;
            r_out_vld <= r_s1_vld;
            if (w_accept)
                r_s1_diff <= w_diff;
            if (r_s1_vld)
                r_out <= w_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= NORM_IDLE;
            r_num_rows <= '0;
            r_rows_in  <= '0;
            r_rows_out <= '0;
            r_mean     <= '0;
            r_inv_var  <= '0;
            r_done     <= 1'b0;
        end else if (!start_norm) begin
            r_state <= NORM_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                NORM_IDLE: begin
                    r_num_rows <= num_rows;
                    r_mean     <= mean;
                    r_inv_var  <= inv_var;
                    r_rows_in  <= '0;
                    r_rows_out <= '0;
                    if (num_rows == '0) begin
                        r_state <= NORM_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= NORM_RUN;
                    end
                end
                NORM_RUN, NORM_DRAIN: begin
                    if (w_accept)
                        r_rows_in <= r_rows_in + CWIDTH'(1);
                    if (w_emit)
                        r_rows_out <= r_rows_out + CWIDTH'(1);
                    // The last emit can only follow the last accept, so it wins.
                    if (w_emit && w_out_last) begin
                        r_state <= NORM_DONE;
                        r_done  <= 1'b1;
                    end else if (r_state == NORM_RUN && w_accept && w_in_last) begin
                        r_state <= NORM_DRAIN;
                    end
                end
                NORM_DONE: r_state <= NORM_DONE;
                default:   r_state <= NORM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_stage.sv
// Randomized self-checking bench for norm_stage against a plain-arithmetic
// reference model; honours NORM_RELU_EN when defined.
module tb_norm_stage;
    localparam int DW = 8;
    localparam int NL = 4;
    localparam int SH = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             reset, start_norm, in_valid, in_ready, out_valid, out_ready, done_norm;
    logic [CW-1:0]    num_rows;
    logic [DW-1:0]    mean, inv_var;
    logic [NL*DW-1:0] in_data, out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NL*DW-1:0] exp_q[$];
    int               acc_cyc_q[$];
    logic [NL*DW-1:0] fixed_q[$];

    norm_stage #(.DWIDTH(DW), .VEC_LANES(NL), .SHIFT(SH), .CWIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start_norm(start_norm), .num_rows(num_rows),
        .mean(mean), .inv_var(inv_var), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .done_norm(done_norm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] x, input logic [DW-1:0] m,
                                               input logic [DW-1:0] s);
        int d, p, r;
        d = int'($signed(x)) - int'($signed(m));
        p = d * int'(s);
        r = p >>> SH;
        if (r > (2**(DW-1)) - 1) r = (2**(DW-1)) - 1;
        if (r < -(2**(DW-1)))    r = -(2**(DW-1));
`ifdef NORM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[DW-1:0];
    endfunction

    function automatic logic [NL*DW-1:0] ref_row(input logic [NL*DW-1:0] row, input logic [DW-1:0] m,
                                                 input logic [DW-1:0] s);
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = ref_lane(row[i*DW +: DW], m, s);
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] next_row();
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        return $urandom;
    endfunction

    // mode 0: always valid/ready; 1: random valid and ready; 2: ready low 3 cycles after first output
    task automatic run_job(input int n, input logic [DW-1:0] m, input logic [DW-1:0] s,
                           input int mode, input string nm);
        int cyc = 0, sent = 0, got = 0, stall = 0, last_emit = -1, a;
        bit first = 0, prev_stall = 0, acc, emt, saw_done = 0;
        logic [NL*DW-1:0] prev_out, cur;
        @(negedge clk);
        num_rows = CW'(n); mean = m; inv_var = s; start_norm = 1'b1;
        cur = next_row();
        while (cyc < 2000) begin
            in_valid = (sent < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_data  = cur;
            if (mode == 1)              out_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && stall > 0) begin out_ready = 1'b0; stall--; end
            else                        out_ready = 1'b1;
            #1;
            if (done_norm) begin saw_done = 1; break; end
            if (prev_stall) check({nm, "_hold"}, out_data, prev_out);
            if (out_valid && !out_ready) check({nm, "_stall_rdy"}, in_ready, 1'b0);
            acc = in_valid && in_ready;
            emt = out_valid && out_ready;
            if (acc) begin
                exp_q.push_back(ref_row(cur, m, s));
                acc_cyc_q.push_back(cyc);
                sent++;
            end
            if (emt) begin
                if (exp_q.size() == 0) check({nm, "_extra_out"}, 1'b1, 1'b0);
                else begin
                    check({nm, "_data"}, out_data, exp_q.pop_front());
                    a = acc_cyc_q.pop_front();
                    if (mode == 0) check({nm, "_latency"}, cyc - a, 2);
                end
                got++;
                last_emit = cyc;
                if (mode == 2 && !first) begin first = 1; stall = 3; end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out_data;
            @(posedge clk);
            if (acc) cur = next_row();
            @(negedge clk);
            cyc++;
        end
        check({nm, "_done_seen"}, saw_done, 1'b1);
        check({nm, "_rows_out"}, got, n);
        check({nm, "_leftover"}, exp_q.size(), 0);
        if (n > 0) check({nm, "_done_timing"}, cyc, last_emit + 1);
        exp_q.delete();
        acc_cyc_q.delete();
        @(negedge clk);
        start_norm = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, "_done_clear"}, done_norm, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start_norm = 1'b0; num_rows = '0; mean = '0; inv_var = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_done", done_norm, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic rows from the worked example
        fixed_q.push_back(32'hfa000a14);
        fixed_q.push_back(32'h0a0a0a1a);
        run_job(2, 8'd10, 8'd32, 0, "basic");
        check("basic_last_row", out_data, 32'h00000020);

        // Saturation: high clamp then low clamp
        fixed_q.push_back(32'h00807f7f);
        run_job(1, 8'h80, 8'd32, 0, "sat_hi");
        check("sat_hi_row", out_data, 32'h7f007f7f);
        fixed_q.push_back(32'h0078509c);
        run_job(1, 8'd100, 8'd32, 0, "sat_lo");
`ifdef NORM_RELU_EN
        check("sat_lo_row", out_data, 32'h00280000);
`else
        check("sat_lo_row", out_data, 32'h8028d880);
`endif

        run_job(4, 8'($urandom), 8'($urandom), 2, "bp");

        // num_rows == 0 goes straight to done with no in_ready pulse
        @(negedge clk);
        num_rows = '0; start_norm = 1'b1;
        #1 check("zero_rdy0", in_ready, 1'b0);
        @(posedge clk); #1 check("zero_rdy1", in_ready, 1'b0);
        @(posedge clk); #1 check("zero_done", done_norm, 1'b1);
        check("zero_rdy2", in_ready, 1'b0);
        @(negedge clk); start_norm = 1'b0;
        @(posedge clk); #1 check("zero_done_clr", done_norm, 1'b0);

        // Abort after one accepted row; the in-flight row must be discarded
        @(negedge clk);
        num_rows = 8'd3; mean = 8'd5; inv_var = 8'd16; start_norm = 1'b1;
        in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        check("abort_rdy", in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        start_norm = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_done", done_norm, 1'b0);
        check("abort_rdy_off", in_ready, 1'b0);
        @(posedge clk); #1;
        check("abort_discard", out_valid, 1'b0);
        run_job(3, 8'($urandom), 8'($urandom), 0, "restart");

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 12), 8'($urandom), 8'($urandom), 1, "rand");

        // Async reset in the middle of a run
        @(negedge clk);
        num_rows = 8'd5; start_norm = 1'b1; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_pre_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data", out_data, '0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_done", done_norm, 1'b0);
        start_norm = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_job(3, 8'($urandom), 8'($urandom), 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
